// File: rtl/mem_dout_sequencer_if.sv
// Write-data bus between the control FSM (master) and the byte-wide write sequencer (slave).
interface mem_dout_sequencer_if #(
  parameter int NUM_SRC    = 6,
  parameter int DATA_WIDTH = 16,
  parameter int BUS_WIDTH  = 8
);
  localparam int NBYTES = DATA_WIDTH / BUS_WIDTH;
  localparam int CW     = $clog2(NBYTES + 1);

  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            src_select;
  logic                          start;
  logic [CW-1:0]                 byte_count;
  logic                          hi_first;
  logic                          mem_wr_req;
  logic                          mem_wr_ack;
  logic [BUS_WIDTH-1:0]          data_out;
  logic [CW-1:0]                 byte_index;
  logic                          busy;
  logic                          done;

  modport master (
    output src_data, src_select, start, byte_count, hi_first, mem_wr_ack,
    input  mem_wr_req, data_out, byte_index, busy, done
  );

  modport slave (
    input  src_data, src_select, start, byte_count, hi_first, mem_wr_ack,
    output mem_wr_req, data_out, byte_index, busy, done
  );
endinterface

// File: rtl/mem_dout_sequencer.sv
// Latches one selected source word on start and writes it out byte by byte over
// acknowledged memory write cycles, ascending or descending lane order.
module mem_dout_sequencer #(
  parameter int NUM_SRC    = 6,
  parameter int DATA_WIDTH = 16,
  parameter int BUS_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               reset,
  mem_dout_sequencer_if.slave bus
);
  localparam int NBYTES = DATA_WIDTH / BUS_WIDTH;
  localparam int CW     = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] sel_word;
  logic [CW-1:0]         lane_q;
  logic [CW-1:0]         left_q;
  logic [CW-1:0]         count_c;
  logic                  desc_q;

  // Ascending scan so the highest set select bit overrides; no bit set leaves channel 0.
  always_comb begin
    sel_word = bus.src_data[DATA_WIDTH-1:0];
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (bus.src_select[i]) sel_word = bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign count_c = (bus.byte_count > CW'(NBYTES)) ? CW'(NBYTES) : bus.byte_count;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (count_c != '0) ? WRITE : FIN;
      WRITE:   if (bus.mem_wr_ack && left_q == CW'(1)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      lane_q <= '0;
      left_q <= '0;
      desc_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && count_c != '0) begin
            word_q <= sel_word;
            left_q <= count_c;
            desc_q <= bus.hi_first;
            lane_q <= bus.hi_first ? count_c - CW'(1) : '0;
          end
        end
        WRITE: begin
          if (bus.mem_wr_ack) begin
            left_q <= left_q - CW'(1);
            lane_q <= desc_q ? lane_q - CW'(1) : lane_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only, so they change solely on the clock edge.
  always_comb begin
    bus.mem_wr_req = (state == WRITE);
    bus.busy       = (state == WRITE);
    bus.done       = (state == FIN);
    bus.byte_index = (state == WRITE) ? lane_q : '0;
    bus.data_out   = '0;
    if (state == WRITE) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (lane_q == CW'(i)) bus.data_out = word_q[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_mem_dout_sequencer.sv
// Bench for mem_dout_sequencer: queue-based transfer model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_dout_sequencer;
  localparam int NUM_SRC = 6;
  localparam int DW      = 16;
  localparam int BW      = 8;
  localparam int NBYTES  = DW / BW;
  localparam int CW      = $clog2(NBYTES + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_dout_sequencer_if #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DW), .BUS_WIDTH(BW)) bus ();

  mem_dout_sequencer #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a pending transfer is just the list of bytes still to be accepted.
  typedef struct {
    logic [BW-1:0] data;
    int            lane;
  } xfer_t;

  xfer_t q[$];
  bit    m_fin = 1'b0;
  bit    chk_en = 1'b0;
  int    m_ch, m_n, m_lane;
  logic [DW-1:0] m_word;
  logic [NUM_SRC*DW-1:0] m_src;
  xfer_t m_x;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_fin = 1'b0;
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (q.size() > 0) begin
      if (bus.mem_wr_ack) begin
        void'(q.pop_front());
        if (q.size() == 0) m_fin = 1'b1;
      end
    end else if (bus.start) begin
      m_ch = 0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (bus.src_select[i]) begin
          m_ch = i;
          break;
        end
      end
      m_src  = bus.src_data >> (m_ch * DW);
      m_word = m_src[DW-1:0];
      m_n    = int'(bus.byte_count);
      if (m_n > NBYTES) m_n = NBYTES;
      for (int k = 0; k < m_n; k++) begin
        m_lane    = bus.hi_first ? (m_n - 1 - k) : k;
        m_x.lane  = m_lane;
        m_x.data  = BW'(m_word >> (m_lane * BW));
        q.push_back(m_x);
      end
      if (m_n == 0) m_fin = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_req",  int'(bus.mem_wr_req), int'(q.size() > 0));
      check("model_busy", int'(bus.busy),       int'(q.size() > 0));
      check("model_done", int'(bus.done),       int'(m_fin));
      check("model_data", int'(bus.data_out),   (q.size() > 0) ? int'(q[0].data) : 0);
      check("model_idx",  int'(bus.byte_index), (q.size() > 0) ? q[0].lane : 0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input int req, input int data, input int idx,
                            input int busy, input int done);
    check({tag, "_req"},  int'(bus.mem_wr_req), req);
    check({tag, "_data"}, int'(bus.data_out),   data);
    check({tag, "_idx"},  int'(bus.byte_index), idx);
    check({tag, "_busy"}, int'(bus.busy),       busy);
    check({tag, "_done"}, int'(bus.done),       done);
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] w);
    bus.src_data[ch*DW +: DW] = w;
  endtask

  initial begin
    bus.src_data   = '0;
    bus.src_select = '0;
    bus.start      = 1'b0;
    bus.byte_count = '0;
    bus.hi_first   = 1'b0;
    bus.mem_wr_ack = 1'b0;

    // Reset held two cycles, then ack pulses while idle.
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    expect_out("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    bus.mem_wr_ack = 1'b1;
    tick();
    bus.mem_wr_ack = 1'b0;
    tick();
    bus.mem_wr_ack = 1'b1;
    tick();
    expect_out("idle_ack", 0, 0, 0, 0, 0);
    bus.mem_wr_ack = 1'b0;

    // Low-first 16-bit with ack held high.
    set_ch(2, 16'hBEEF);
    bus.src_select = 6'b000100;
    bus.byte_count = 2'd2;
    bus.hi_first   = 1'b0;
    bus.mem_wr_ack = 1'b1;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_out("lo_b0", 1, 8'hEF, 0, 1, 0);
    tick();
    expect_out("lo_b1", 1, 8'hBE, 1, 1, 0);
    tick();
    expect_out("lo_fin", 0, 0, 0, 0, 1);
    tick();
    expect_out("lo_idle", 0, 0, 0, 0, 0);

    // High-first with three wait cycles per byte.
    set_ch(5, 16'h1234);
    bus.src_select = 6'b100000;
    bus.hi_first   = 1'b1;
    bus.mem_wr_ack = 1'b0;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int w = 0; w < 3; w++) begin
      expect_out("hi_wait1", 1, 8'h12, 1, 1, 0);
      if (w < 2) tick();
    end
    bus.mem_wr_ack = 1'b1;
    tick();
    bus.mem_wr_ack = 1'b0;
    for (int w = 0; w < 3; w++) begin
      expect_out("hi_wait0", 1, 8'h34, 0, 1, 0);
      if (w < 2) tick();
    end
    bus.mem_wr_ack = 1'b1;
    tick();
    bus.mem_wr_ack = 1'b0;
    expect_out("hi_fin", 0, 0, 0, 0, 1);
    tick();

    // Single byte, then zero byte.
    set_ch(4, 16'h00A5);
    bus.src_select = 6'b010000;
    bus.byte_count = 2'd1;
    bus.hi_first   = 1'b0;
    bus.mem_wr_ack = 1'b1;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_out("one_b0", 1, 8'hA5, 0, 1, 0);
    tick();
    expect_out("one_fin", 0, 0, 0, 0, 1);
    tick();
    bus.byte_count = 2'd0;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_out("zero_fin", 0, 0, 0, 0, 1);
    tick();
    expect_out("zero_idle", 0, 0, 0, 0, 0);

    // Priority: ch5 over ch0, source changes after start do not leak in.
    set_ch(0, 16'h1111);
    set_ch(5, 16'hCAFE);
    bus.src_select = 6'b100001;
    bus.byte_count = 2'd2;
    bus.mem_wr_ack = 1'b0;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_out("pri_b0", 1, 8'hFE, 0, 1, 0);
    set_ch(5, 16'h0000);
    bus.mem_wr_ack = 1'b1;
    tick();
    expect_out("pri_b1", 1, 8'hCA, 1, 1, 0);
    tick();
    tick();

    // Empty select falls back to channel 0.
    set_ch(0, 16'h5A3C);
    bus.src_select = '0;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_out("sel0_b0", 1, 8'h3C, 0, 1, 0);
    tick();
    expect_out("sel0_b1", 1, 8'h5A, 1, 1, 0);
    tick();
    tick();

    // Start during WRITE and during FIN is ignored.
    set_ch(2, 16'hBEEF);
    bus.src_select = 6'b000100;
    bus.mem_wr_ack = 1'b0;
    bus.start      = 1'b1;
    tick();
    bus.src_select = 6'b000001;
    bus.byte_count = 2'd1;
    tick();
    expect_out("busy_start", 1, 8'hEF, 0, 1, 0);
    bus.mem_wr_ack = 1'b1;
    tick();
    expect_out("busy_b1", 1, 8'hBE, 1, 1, 0);
    tick();
    expect_out("busy_fin", 0, 0, 0, 0, 1);
    tick();
    expect_out("fin_start", 0, 0, 0, 0, 0);
    bus.start = 1'b0;
    tick();

    // Reset after the first accepted byte abandons the transfer.
    bus.src_select = 6'b000100;
    bus.byte_count = 2'd2;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    expect_out("rst_b1", 1, 8'hBE, 1, 1, 0);
    reset = 1'b1;
    tick();
    expect_out("rst_drop", 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    expect_out("rst_nodone", 0, 0, 0, 0, 0);
    bus.hi_first = 1'b1;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_out("rst_after", 1, 8'hBE, 1, 1, 0);
    tick();
    tick();
    tick();

    // Randomized traffic, including oversize counts and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 199) == 0);
      bus.src_data   = {$urandom(), $urandom(), $urandom()};
      bus.src_select = ($urandom_range(0, 4) == 0) ? '0 : NUM_SRC'($urandom());
      bus.start      = ($urandom_range(0, 2) == 0);
      bus.byte_count = CW'($urandom_range(0, 3));
      bus.hi_first   = $urandom_range(0, 1) == 1;
      bus.mem_wr_ack = ($urandom_range(0, 2) != 0);
      tick();
    end
    reset = 1'b0;
    bus.start = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
